// File: rtl/fft_bfly_combine.sv
// Radix-2 butterfly combiner: queues A, emits A+W*B / A-W*B on product.
// Ports: clk, reset_n, A in (in_*), product in (prod_*), X0/X1 out, flags.
module fft_bfly_combine #(
  parameter int DATA_FFT_SIZE = 16,
  parameter int SIZE_DATA_FI  = 6,
  parameter     COMPENS_FP    = "false",
  parameter     SCALE         = "none",
  parameter int FIFO_DEPTH    = 8,
  localparam int WP = (COMPENS_FP == "add") ?
                      DATA_FFT_SIZE + 1 : DATA_FFT_SIZE,
  localparam int WO = (SCALE == "half") ? WP : WP + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DATA_FFT_SIZE-1:0] in_top_i,
  input  logic [DATA_FFT_SIZE-1:0] in_top_q,
  input  logic          prod_valid,
  input  logic [WP-1:0] prod_i,
  input  logic [WP-1:0] prod_q,
  output logic          out_valid,
  output logic [WO-1:0] out_sum_i,
  output logic [WO-1:0] out_sum_q,
  output logic [WO-1:0] out_dif_i,
  output logic [WO-1:0] out_dif_q,
  output logic          out_last,
  output logic          err_overflow,
  output logic          err_underflow
);

  localparam int D  = DATA_FFT_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = SIZE_DATA_FI - 1;
  localparam bit ADD  = (COMPENS_FP == "add");
  localparam bit HALF = (SCALE == "half");

  logic [2*D-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level;
  logic [CW-1:0]  pair_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = prod_valid & ~empty;
  // A full FIFO still accepts A when the same cycle frees a slot.
  assign push  = in_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_top_i, in_top_q};
  end

  logic [D-1:0] a_i;
  logic [D-1:0] a_q;
  assign a_i = mem[rd_ptr][2*D-1:D];
  assign a_q = mem[rd_ptr][D-1:0];

  logic [WP-1:0] al_i;
  logic [WP-1:0] al_q;

  // "add" products carry one extra fractional bit, so A moves up by one.
  if (ADD) begin : g_al_add
    assign al_i = {a_i, 1'b0};
    assign al_q = {a_q, 1'b0};
  end else begin : g_al_pass
    assign al_i = a_i;
    assign al_q = a_q;
  end

  logic [WP:0] s_i;
  logic [WP:0] s_q;
  logic [WP:0] d_i;
  logic [WP:0] d_q;

  assign s_i = {al_i[WP-1], al_i} + {prod_i[WP-1], prod_i};
  assign s_q = {al_q[WP-1], al_q} + {prod_q[WP-1], prod_q};
  assign d_i = {al_i[WP-1], al_i} - {prod_i[WP-1], prod_i};
  assign d_q = {al_q[WP-1], al_q} - {prod_q[WP-1], prod_q};

  logic [WO-1:0] r_si;
  logic [WO-1:0] r_sq;
  logic [WO-1:0] r_di;
  logic [WO-1:0] r_dq;

  if (HALF) begin : g_half
    // Round half up, then drop the guard bit; |full| < 2^WP keeps it exact.
    function automatic logic [WP-1:0] rnd(input logic [WP:0] x);
      logic [WP+1:0] t;
      t = {x[WP], x} + (WP+2)'(1);
      return t[WP:1];
    endfunction
    assign r_si = rnd(s_i);
    assign r_sq = rnd(s_q);
    assign r_di = rnd(d_i);
    assign r_dq = rnd(d_q);
  end else begin : g_full
    assign r_si = s_i;
    assign r_sq = s_q;
    assign r_di = d_i;
    assign r_dq = d_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      pair_cnt      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_sum_i     <= '0;
      out_sum_q     <= '0;
      out_dif_i     <= '0;
      out_dif_q     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      level     <= level + (AW+1)'(push) - (AW+1)'(pop);
      out_valid <= pop;
      out_last  <= pop & (&pair_cnt);
      if (pop) begin
        out_sum_i <= r_si;
        out_sum_q <= r_sq;
        out_dif_i <= r_di;
        out_dif_q <= r_dq;
        pair_cnt  <= pair_cnt + CW'(1);
      end
      if (in_valid & full & ~pop) err_overflow <= 1'b1;
      if (prod_valid & empty)     err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_bfly_combine.sv
// Bench for fft_bfly_combine: two configurations share one stimulus and
// are checked against a list-based reference model each clock.
module tb_fft_bfly_combine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic in_valid;
  logic prod_valid;
  logic signed [15:0] a_i, a_q;
  logic signed [15:0] p0_i, p0_q;
  logic signed [16:0] p1_i, p1_q;

  logic v0, l0, ov0, un0;
  logic v1, l1, ov1, un1;
  logic signed [16:0] si0, sq0, di0, dq0;
  logic signed [16:0] si1, sq1, di1, dq1;

  fft_bfly_combine #(
    .DATA_FFT_SIZE(16), .SIZE_DATA_FI(3),
    .COMPENS_FP("false"), .SCALE("none"), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_top_i(a_i), .in_top_q(a_q),
    .prod_valid(prod_valid), .prod_i(p0_i), .prod_q(p0_q),
    .out_valid(v0), .out_sum_i(si0), .out_sum_q(sq0),
    .out_dif_i(di0), .out_dif_q(dq0), .out_last(l0),
    .err_overflow(ov0), .err_underflow(un0)
  );

  fft_bfly_combine #(
    .DATA_FFT_SIZE(16), .SIZE_DATA_FI(6),
    .COMPENS_FP("add"), .SCALE("half"), .FIFO_DEPTH(8)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_top_i(a_i), .in_top_q(a_q),
    .prod_valid(prod_valid), .prod_i(p1_i), .prod_q(p1_q),
    .out_valid(v1), .out_sum_i(si1), .out_sum_q(sq1),
    .out_dif_i(di1), .out_dif_q(dq1), .out_last(l1),
    .err_overflow(ov1), .err_underflow(un1)
  );

  // Reference model: per instance, a list of queued A values.
  int depth [2] = '{4, 8};
  int npair [2] = '{4, 32};
  int mul   [2] = '{1, 2};
  bit half  [2] = '{1'b0, 1'b1};

  int mi [2][16];
  int mq [2][16];
  int lvl  [2];
  int done [2];
  bit e_v [2], e_l [2], e_ov [2], e_un [2];
  int e_si [2], e_sq [2], e_di [2], e_dq [2];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic int scl(int x, bit h);
    if (!h) return x;
    return (x + 1) >>> 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lvl[k] = 0; done[k] = 0;
      e_v[k] = 0; e_l[k] = 0; e_ov[k] = 0; e_un[k] = 0;
      e_si[k] = 0; e_sq[k] = 0; e_di[k] = 0; e_dq[k] = 0;
    end
  endtask

  task automatic model_edge(bit iv, int ai, int aq,
                            bit pv, int pi, int pq);
    bit pop, full;
    int xi, xq;
    for (int k = 0; k < 2; k++) begin
      pop  = pv && (lvl[k] > 0);
      full = (lvl[k] == depth[k]);
      if (pv && lvl[k] == 0) e_un[k] = 1;
      if (iv && full && !pop) e_ov[k] = 1;
      e_v[k] = pop;
      e_l[k] = 0;
      if (pop) begin
        xi = mi[k][0] * mul[k];
        xq = mq[k][0] * mul[k];
        e_si[k] = scl(xi + pi, half[k]);
        e_sq[k] = scl(xq + pq, half[k]);
        e_di[k] = scl(xi - pi, half[k]);
        e_dq[k] = scl(xq - pq, half[k]);
        e_l[k] = (done[k] % npair[k]) == npair[k] - 1;
        done[k]++;
        for (int j = 0; j < 15; j++) begin
          mi[k][j] = mi[k][j+1];
          mq[k][j] = mq[k][j+1];
        end
        lvl[k]--;
      end
      if (iv && (!full || pop)) begin
        mi[k][lvl[k]] = ai;
        mq[k][lvl[k]] = aq;
        lvl[k]++;
      end
    end
  endtask

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(string n, int k, logic v, logic l,
                          logic ov, logic un,
                          logic signed [16:0] si, logic signed [16:0] sq,
                          logic signed [16:0] di, logic signed [16:0] dq);
    chk({n, ".out_valid"}, {31'd0, v}, {31'd0, e_v[k]});
    chk({n, ".out_last"}, {31'd0, l}, {31'd0, e_l[k]});
    chk({n, ".err_overflow"}, {31'd0, ov}, {31'd0, e_ov[k]});
    chk({n, ".err_underflow"}, {31'd0, un}, {31'd0, e_un[k]});
    chk({n, ".sum_i"}, si, e_si[k]);
    chk({n, ".sum_q"}, sq, e_sq[k]);
    chk({n, ".dif_i"}, di, e_di[k]);
    chk({n, ".dif_q"}, dq, e_dq[k]);
  endtask

  task automatic check_all();
    chk_inst("u0", 0, v0, l0, ov0, un0, si0, sq0, di0, dq0);
    chk_inst("u1", 1, v1, l1, ov1, un1, si1, sq1, di1, dq1);
  endtask

  task automatic step(bit iv, int ai, int aq, bit pv, int pi, int pq);
    @(negedge clk);
    in_valid   = iv;
    a_i        = 16'(ai);
    a_q        = 16'(aq);
    prod_valid = pv;
    p0_i = 16'(pi);
    p0_q = 16'(pq);
    p1_i = 17'(pi);
    p1_q = 17'(pq);
    @(posedge clk);
    model_edge(iv, ai, aq, pv, pi, pq);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges; outputs must clear before any edge.
  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 0;
    prod_valid = 0;
    #2 reset_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    in_valid = 0; prod_valid = 0;
    a_i = 0; a_q = 0;
    p0_i = 0; p0_q = 0; p1_i = 0; p1_q = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset_n = 1;

    // Basic pair, product three cycles after A.
    step(1, 1000, -200, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 300, 50);
    idle(2);

    // Rounding and alignment cases.
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, -3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 100, 0, 0, 0, 0);
    step(0, 0, 0, 1, 50, -50);
    idle(1);

    // Eight pushes, products four cycles behind, back to back.
    for (int t = 0; t < 12; t++)
      step(t < 8, 10 * t + 1, -7 * t, t >= 4, 3 * t, t - 20);
    idle(1);

    // Full FIFO, then push+pop, then dropped push, then drain past empty.
    for (int t = 0; t < 4; t++) step(1, 500 + t, t, 0, 0, 0);
    step(1, 600, 6, 1, 1, 1);
    step(1, 700, 7, 0, 0, 0);
    for (int t = 0; t < 7; t++) step(0, 0, 0, 1, t, -t);
    idle(1);

    // Reset mid-frame with entries queued.
    step(1, 11, 1, 0, 0, 0);
    step(0, 0, 0, 1, 2, 2);
    for (int t = 0; t < 3; t++) step(1, 20 + t, t, 0, 0, 0);
    pulse_reset();
    step(0, 0, 0, 1, 9, 9);
    for (int t = 0; t < 4; t++) begin
      step(1, 40 + t, -t, 0, 0, 0);
      step(0, 0, 0, 1, t, 2 * t);
    end
    idle(1);

    // Random traffic from a clean state.
    pulse_reset();
    for (int t = 0; t < 400; t++)
      step($urandom_range(0, 1) == 1,
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
